// File: rtl/fir_shift_add_pipe.sv
// Parametrised shift-coefficient FIR with valid/ready flow control, flush and run-time approximate adders.
// Optional build macro FIR_SAT_EN: saturate the accumulator to DW bits instead of wrapping.
module fir_shift_add_pipe #(
    parameter int unsigned            DW       = 16,
    parameter int unsigned            TAPS     = 5,
    parameter logic [4*TAPS-1:0]      SHIFTS   = 20'h12345,
    parameter int unsigned            APPROX_K = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          approx_en,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] dataout
);

    localparam int unsigned AW = DW + 3;

    logic [DW-1:0] taps [TAPS];
    logic [DW-1:0] nxt  [TAPS];
    logic [AW-1:0] acc;
    logic [DW-1:0] result;
    logic          accept;

    // Low K bits see only the carry from the bit directly below; the upper part is exact.
    function automatic logic [AW-1:0] add_sel(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic          apx);
        logic [AW-1:0] lo;
        logic          c;
        if (!apx || APPROX_K == 0) begin
            return a + b;
        end
        lo = '0;
        c  = 1'b0;
        for (int unsigned i = 0; i < APPROX_K; i++) begin
            lo[i] = a[i] ^ b[i] ^ c;
            c     = a[i] & b[i];
        end
        return (((a >> APPROX_K) + (b >> APPROX_K) + {{(AW-1){1'b0}}, c}) << APPROX_K) | lo;
    endfunction

    assign in_ready = !flush && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        nxt[0] = x;
        for (int unsigned i = 1; i < TAPS; i++) begin
            nxt[i] = taps[i-1];
        end
        acc = AW'(nxt[0] >> SHIFTS[3:0]);
        for (int unsigned i = 1; i < TAPS; i++) begin
            acc = add_sel(acc, AW'(nxt[i] >> SHIFTS[4*i +: 4]), approx_en);
        end
    end

`ifdef FIR_SAT_EN
    assign result = (acc[AW-1:DW] != '0) ? '1 : acc[DW-1:0];
`else
    logic [AW-DW-1:0] acc_hi_unused;
    assign acc_hi_unused = acc[AW-1:DW];
    assign result        = acc[DW-1:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                taps[i] <= '0;
            end
            out_valid <= 1'b0;
            dataout   <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                taps[i] <= '0;
            end
            out_valid <= 1'b0;
        end else if (accept) begin
            for (int unsigned i = 0; i < TAPS; i++) begin
                taps[i] <= nxt[i];
            end
            out_valid <= 1'b1;
            dataout   <= result;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
